// File: rtl/eyeriss_pkg.sv
// Shared types and constants for the Eyeriss NoC scheduler.
// Covers FSM states, requester class encoding, bus widths and config word field positions.
package eyeriss_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned CONF_W = 26;
    localparam int unsigned XFER_W = 16;

    // Field positions in {enable, psum_src, mult_bits, maplen, filterlen, id}
    localparam int unsigned CONF_EN_BIT       = 25;
    localparam int unsigned CONF_PSUM_SRC_BIT = 24;
    localparam int unsigned CONF_ID_MSB       = 7;
    localparam int unsigned CONF_ID_LSB       = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_FIL  = 2'd0,
        CLS_MAP  = 2'd1,
        CLS_PSUM = 2'd2
    } cls_e;

    function automatic logic [1:0] cls_next(input logic [1:0] c);
        return (c == 2'(CLS_PSUM)) ? 2'(CLS_FIL) : c + 2'd1;
    endfunction

endpackage

// File: rtl/eyeriss_noc_scheduler_if.sv
// Request/bus bundle between the scheduler and its requesters and PE array.
// The scheduler side uses the master modport; requesters and the array use slave.
interface eyeriss_noc_scheduler_if;
    import eyeriss_pkg::*;

    logic              start_i;
    logic              end_i;
    logic [CONF_W-1:0] conf_word_i;
    logic              fil_valid_i;
    logic              map_valid_i;
    logic              psum_valid_i;
    logic [ID_W-1:0]   fil_id_i;
    logic [ID_W-1:0]   map_id_i;
    logic [ID_W-1:0]   psum_id_i;
    logic [DATA_W-1:0] fil_data_i;
    logic [DATA_W-1:0] map_data_i;
    logic [DATA_W-1:0] psum_data_i;
    logic              fil_ready_o;
    logic              map_ready_o;
    logic              psum_ready_o;
    logic              stall_i;
    logic              pe_ready_i;
    logic [DATA_W-1:0] bus_data_o;
    logic [ID_W-1:0]   bus_id_o;
    logic              getdata_fil_o;
    logic              getdata_map_o;
    logic              getdata_psum_o;
    logic [CONF_W-1:0] conf_o;
    logic              busy_o;
    logic              done_o;
    logic [XFER_W-1:0] xfer_cnt_o;

    modport master (
        input  start_i, end_i, conf_word_i,
        input  fil_valid_i, map_valid_i, psum_valid_i,
        input  fil_id_i, map_id_i, psum_id_i,
        input  fil_data_i, map_data_i, psum_data_i,
        input  stall_i, pe_ready_i,
        output fil_ready_o, map_ready_o, psum_ready_o,
        output bus_data_o, bus_id_o,
        output getdata_fil_o, getdata_map_o, getdata_psum_o,
        output conf_o, busy_o, done_o, xfer_cnt_o
    );

    modport slave (
        output start_i, end_i, conf_word_i,
        output fil_valid_i, map_valid_i, psum_valid_i,
        output fil_id_i, map_id_i, psum_id_i,
        output fil_data_i, map_data_i, psum_data_i,
        output stall_i, pe_ready_i,
        input  fil_ready_o, map_ready_o, psum_ready_o,
        input  bus_data_o, bus_id_o,
        input  getdata_fil_o, getdata_map_o, getdata_psum_o,
        input  conf_o, busy_o, done_o, xfer_cnt_o
    );

endinterface

// File: rtl/eyeriss_rr_arbiter3.sv
// Three-way round-robin arbiter (fil -> map -> psum); after a grant to class k,
// class k+1 has the highest priority on the next cycle.
module eyeriss_rr_arbiter3
    import eyeriss_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,
    input  logic       i_en,
    output logic [2:0] o_grant_c
);

    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic       w_found;

    // Walk the classes starting at the pointer; the first requester wins
    always_comb begin
        o_grant_c = 3'b000;
        w_found   = 1'b0;
        w_idx     = r_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!w_found) begin
                if (i_en && i_req[w_idx]) begin
                    o_grant_c[w_idx] = 1'b1;
                    w_found          = 1'b1;
                end else begin
                    w_idx = cls_next(w_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'(CLS_FIL);
        end else if (w_found) begin
            r_ptr <= cls_next(w_idx);
        end
    end

endmodule

// File: rtl/eyeriss_noc_scheduler.sv
// Pass sequencer for the PE array: broadcasts the config word, arbitrates the
// GLB->PE multicast bus among filter/ifmap/psum, then drains and signals completion.
module eyeriss_noc_scheduler
    import eyeriss_pkg::*;
#(
    parameter int unsigned CONF_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    Rst,
    eyeriss_noc_scheduler_if.master io
);

    localparam int unsigned CFG_CNT_W = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;

    state_e                r_state;
    logic [CFG_CNT_W-1:0]  r_cfg_cnt;
    logic                  r_end;
    logic [CONF_W-1:0]     r_conf;
    logic [2:0]            r_strobe;
    logic [DATA_W-1:0]     r_bus_data;
    logic [ID_W-1:0]       r_bus_id;
    logic [XFER_W-1:0]     r_xfer_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [2:0]            w_req;
    logic                  w_en;
    logic [2:0]            w_grant;
    logic [DATA_W-1:0]     w_data;
    logic [ID_W-1:0]       w_id;

    assign w_req = {io.psum_valid_i, io.map_valid_i, io.fil_valid_i};
    assign w_en  = (r_state == ST_RUN) && !io.stall_i;

    eyeriss_rr_arbiter3 u_arb (
        .clk       (CLK),
        .rst       (Rst),
        .i_req     (w_req),
        .i_en      (w_en),
        .o_grant_c (w_grant)
    );

    // Payload of the granted class
    always_comb begin
        w_data = io.fil_data_i;
        w_id   = io.fil_id_i;
        if (w_grant[CLS_MAP]) begin
            w_data = io.map_data_i;
            w_id   = io.map_id_i;
        end else if (w_grant[CLS_PSUM]) begin
            w_data = io.psum_data_i;
            w_id   = io.psum_id_i;
        end
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_cfg_cnt  <= '0;
            r_end      <= 1'b0;
            r_conf     <= '0;
            r_strobe   <= 3'b000;
            r_bus_data <= '0;
            r_bus_id   <= '0;
            r_xfer_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_strobe <= w_grant;
            r_done   <= 1'b0;
            if (|w_grant) begin
                r_bus_data <= w_data;
                r_bus_id   <= w_id;
                r_xfer_cnt <= r_xfer_cnt + XFER_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (io.start_i) begin
                        r_state    <= ST_CONFIG;
                        r_conf     <= io.conf_word_i;
                        r_xfer_cnt <= '0;
                        r_end      <= 1'b0;
                        r_cfg_cnt  <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_CONFIG: begin
                    if (io.end_i) r_end <= 1'b1;
                    if (r_cfg_cnt == CFG_CNT_W'(CONF_CYCLES - 1)) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cfg_cnt <= r_cfg_cnt + CFG_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (io.end_i) r_end <= 1'b1;
                    if (r_end && !(|w_req)) r_state <= ST_DRAIN;
                end
                // Wait for the array to settle and the last strobe to leave the bus
                ST_DRAIN: begin
                    if (io.pe_ready_i && !(|r_strobe)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io.fil_ready_o    = w_grant[CLS_FIL];
    assign io.map_ready_o    = w_grant[CLS_MAP];
    assign io.psum_ready_o   = w_grant[CLS_PSUM];
    assign io.getdata_fil_o  = r_strobe[CLS_FIL];
    assign io.getdata_map_o  = r_strobe[CLS_MAP];
    assign io.getdata_psum_o = r_strobe[CLS_PSUM];
    assign io.bus_data_o     = r_bus_data;
    assign io.bus_id_o       = r_bus_id;
    assign io.conf_o         = r_conf;
    assign io.busy_o         = r_busy;
    assign io.done_o         = r_done;
    assign io.xfer_cnt_o     = r_xfer_cnt;

endmodule

// File: tb/tb_eyeriss_noc_scheduler.sv
// Bench for eyeriss_noc_scheduler: directed vector table, randomized traffic against
// a pass-level reference model, and an asynchronous reset in the middle of a pass.
module tb_eyeriss_noc_scheduler;

    localparam int unsigned CONF_CYCLES = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    eyeriss_noc_scheduler_if ifc ();

    eyeriss_noc_scheduler #(.CONF_CYCLES(CONF_CYCLES)) dut (
        .CLK (clk),
        .Rst (rst),
        .io  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one pass, kept as plain phase/counter variables
    typedef enum int {P_IDLE, P_CFG, P_RUN, P_DRAIN, P_DONE} phase_t;
    phase_t      m_phase;
    int          m_ptr;
    int          m_cfg_left;
    bit          m_end;
    logic [25:0] m_conf;
    logic [15:0] m_cnt;
    logic [15:0] m_data;
    logic [7:0]  m_id;
    logic [2:0]  m_gd;

    typedef struct packed {
        logic        start;
        logic        endp;
        logic        stall;
        logic        pe_rdy;
        logic [2:0]  vld;
        logic [2:0]  rdy;
        logic [2:0]  gd;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = P_IDLE;
        m_ptr = 0;
        m_cfg_left = 0;
        m_end = 1'b0;
        m_conf = '0;
        m_cnt = '0;
        m_data = '0;
        m_id = '0;
        m_gd = 3'b000;
    endtask

    function automatic int m_grant();
        logic [2:0] v;
        v = {ifc.psum_valid_i, ifc.map_valid_i, ifc.fil_valid_i};
        if (m_phase != P_RUN || ifc.stall_i) return -1;
        for (int k = 0; k < 3; k++) begin
            if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic m_step(input int g);
        logic [2:0]  prev_gd;
        logic [15:0] d [3];
        logic [7:0]  id [3];
        bit          any_v;
        bit          old_end;
        d[0] = ifc.fil_data_i;  d[1] = ifc.map_data_i;  d[2] = ifc.psum_data_i;
        id[0] = ifc.fil_id_i;   id[1] = ifc.map_id_i;   id[2] = ifc.psum_id_i;
        any_v = ifc.fil_valid_i | ifc.map_valid_i | ifc.psum_valid_i;
        prev_gd = m_gd;
        old_end = m_end;
        m_gd = 3'b000;
        if (g >= 0) begin
            m_gd[g] = 1'b1;
            m_data = d[g];
            m_id = id[g];
            m_cnt = m_cnt + 16'd1;
            m_ptr = (g + 1) % 3;
        end
        case (m_phase)
            P_IDLE: if (ifc.start_i) begin
                m_phase = P_CFG;
                m_cfg_left = CONF_CYCLES;
                m_conf = ifc.conf_word_i;
                m_cnt = '0;
                m_end = 1'b0;
            end
            P_CFG: begin
                if (ifc.end_i) m_end = 1'b1;
                m_cfg_left--;
                if (m_cfg_left == 0) m_phase = P_RUN;
            end
            P_RUN: begin
                if (ifc.end_i) m_end = 1'b1;
                if (old_end && !any_v) m_phase = P_DRAIN;
            end
            P_DRAIN: if (ifc.pe_ready_i && prev_gd == 3'b000) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Inputs are already applied; check ready against the model, return the model grant
    task automatic pre_edge(output int g);
        #1;
        g = m_grant();
        chk("fil_ready", 32'(ifc.fil_ready_o), 32'(g == 0));
        chk("map_ready", 32'(ifc.map_ready_o), 32'(g == 1));
        chk("psum_ready", 32'(ifc.psum_ready_o), 32'(g == 2));
    endtask

    task automatic post_edge(input int g);
        @(posedge clk);
        m_step(g);
        @(negedge clk);
        chk("strobes", 32'({ifc.getdata_psum_o, ifc.getdata_map_o, ifc.getdata_fil_o}), 32'(m_gd));
        chk("bus_data", 32'(ifc.bus_data_o), 32'(m_data));
        chk("bus_id", 32'(ifc.bus_id_o), 32'(m_id));
        chk("conf", 32'(ifc.conf_o), 32'(m_conf));
        chk("xfer_cnt", 32'(ifc.xfer_cnt_o), 32'(m_cnt));
        chk("busy", 32'(ifc.busy_o), 32'(m_phase != P_IDLE));
        chk("done", 32'(ifc.done_o), 32'(m_phase == P_DONE));
    endtask

    task automatic run_cycle();
        int g;
        pre_edge(g);
        post_edge(g);
    endtask

    function automatic vec_t mk(input logic st, input logic en, input logic sl, input logic pr,
                                input logic [2:0] v, input logic [2:0] r, input logic [2:0] gd,
                                input logic [15:0] c, input logic b, input logic d);
        vec_t t;
        t = '{st, en, sl, pr, v, r, gd, c, b, d};
        return t;
    endfunction

    task automatic set_inputs(input logic st, input logic en, input logic sl, input logic pr,
                              input logic [2:0] v);
        ifc.start_i = st;
        ifc.end_i = en;
        ifc.stall_i = sl;
        ifc.pe_ready_i = pr;
        ifc.fil_valid_i = v[0];
        ifc.map_valid_i = v[1];
        ifc.psum_valid_i = v[2];
    endtask

    initial begin
        int g;
        checks = 0;
        errors = 0;
        // start, end, stall, pe_rdy, vld, rdy, strobes, cnt, busy, done
        tbl[0]  = mk(1, 0, 0, 1, 3'b000, 3'b000, 3'b000, 16'd0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 16'd0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 16'd0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 3'b111, 3'b001, 3'b001, 16'd1, 1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 3'b111, 3'b010, 3'b010, 16'd2, 1, 0);
        tbl[5]  = mk(0, 0, 0, 1, 3'b111, 3'b100, 3'b100, 16'd3, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 3'b111, 3'b001, 3'b001, 16'd4, 1, 0);
        tbl[7]  = mk(0, 0, 1, 1, 3'b010, 3'b000, 3'b000, 16'd4, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 3'b010, 3'b000, 3'b000, 16'd4, 1, 0);
        tbl[9]  = mk(0, 0, 1, 1, 3'b010, 3'b000, 3'b000, 16'd4, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 3'b010, 3'b010, 3'b010, 16'd5, 1, 0);
        tbl[11] = mk(1, 0, 0, 1, 3'b100, 3'b100, 3'b100, 16'd6, 1, 0);
        tbl[12] = mk(0, 1, 0, 0, 3'b100, 3'b100, 3'b100, 16'd7, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 16'd7, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 16'd7, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 16'd7, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 16'd7, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 16'd7, 1, 0);
        tbl[18] = mk(0, 0, 0, 1, 3'b000, 3'b000, 3'b000, 16'd7, 1, 1);
        tbl[19] = mk(0, 0, 0, 1, 3'b000, 3'b000, 3'b000, 16'd7, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 3'b000, 3'b000, 3'b000, 16'd7, 0, 0);

        rst = 1'b1;
        set_inputs(0, 0, 0, 1, 3'b111);
        ifc.conf_word_i = 26'h2000105;
        ifc.fil_id_i = 8'd1;  ifc.fil_data_i = 16'hAAAA;
        ifc.map_id_i = 8'd2;  ifc.map_data_i = 16'hBBBB;
        ifc.psum_id_i = 8'd3; ifc.psum_data_i = 16'hCCCC;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'({ifc.psum_ready_o, ifc.map_ready_o, ifc.fil_ready_o}), 32'd0);
        chk("rst_strobes", 32'({ifc.getdata_psum_o, ifc.getdata_map_o, ifc.getdata_fil_o}), 32'd0);
        chk("rst_busy_done", 32'({ifc.busy_o, ifc.done_o}), 32'd0);
        chk("rst_bus", 32'({ifc.bus_id_o, ifc.bus_data_o}), 32'd0);
        chk("rst_conf", 32'(ifc.conf_o), 32'd0);
        chk("rst_xfer_cnt", 32'(ifc.xfer_cnt_o), 32'd0);
        rst = 1'b0;

        // Directed pass: config, round-robin, stall, ignored start, end+drain, done
        for (int i = 0; i < 21; i++) begin
            set_inputs(tbl[i].start, tbl[i].endp, tbl[i].stall, tbl[i].pe_rdy, tbl[i].vld);
            ifc.conf_word_i = (i == 11) ? 26'h1234567 : 26'h2000105;
            pre_edge(g);
            chk($sformatf("tbl%0d_ready", i),
                32'({ifc.psum_ready_o, ifc.map_ready_o, ifc.fil_ready_o}), 32'(tbl[i].rdy));
            post_edge(g);
            chk($sformatf("tbl%0d_strobes", i),
                32'({ifc.getdata_psum_o, ifc.getdata_map_o, ifc.getdata_fil_o}), 32'(tbl[i].gd));
            chk($sformatf("tbl%0d_xfer_cnt", i), 32'(ifc.xfer_cnt_o), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_busy", i), 32'(ifc.busy_o), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(ifc.done_o), 32'(tbl[i].done));
            if (i == 0 || i == 11)
                chk($sformatf("tbl%0d_conf", i), 32'(ifc.conf_o), 32'h2000105);
            if (i == 3)
                chk("tbl3_bus", 32'({ifc.bus_id_o, ifc.bus_data_o}), 32'h01AAAA);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            set_inputs(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)));
            ifc.conf_word_i = 26'($urandom);
            ifc.fil_id_i = 8'($urandom);   ifc.fil_data_i = 16'($urandom);
            ifc.map_id_i = 8'($urandom);   ifc.map_data_i = 16'($urandom);
            ifc.psum_id_i = 8'($urandom);  ifc.psum_data_i = 16'($urandom);
            run_cycle();
        end

        // Asynchronous reset while a strobe is on the bus
        rst = 1'b1;
        set_inputs(0, 0, 0, 1, 3'b000);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        set_inputs(1, 0, 0, 1, 3'b000);
        run_cycle();
        set_inputs(0, 0, 0, 1, 3'b001);
        run_cycle();
        run_cycle();
        run_cycle();
        chk("pre_rst_strobe", 32'(ifc.getdata_fil_o), 32'd1);
        rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_strobes", 32'({ifc.getdata_psum_o, ifc.getdata_map_o, ifc.getdata_fil_o}), 32'd0);
        chk("mid_rst_ready", 32'({ifc.psum_ready_o, ifc.map_ready_o, ifc.fil_ready_o}), 32'd0);
        chk("mid_rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("mid_rst_xfer_cnt", 32'(ifc.xfer_cnt_o), 32'd0);
        chk("mid_rst_conf", 32'(ifc.conf_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_cycle();
        run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eyeriss_noc_scheduler.md
# eyeriss_noc_scheduler

Sequences one processing pass of the PE array: broadcasts the 26-bit configuration word, then shares the single GLB→PE multicast bus between three requesters (filter, ifmap, psum) using round-robin arbitration. It drives the id-tagged bus and the `getdata_fil/map/psum` strobes that every PE compares against its configured id. When the pass ends, it drains and reports completion.

## Interface
Parameters:
- `DATA_W`, 16, bus data width
- `ID_W`, 8, PE id width
- `CONF_W`, 26, configuration word width: {enable, psum_src, mult_bits[3:0], maplen[3:0], filterlen[7:0], id[7:0]}
- `CONF_CYCLES`, 2, number of cycles the CONFIG state lasts (≥1)

Ports:
- `CLK`  in  1  single clock, rising edge
- `Rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  pulse; begins a pass when IDLE
- `end_i`  in  1  pulse; last request of the pass has been queued
- `conf_word_i`  in  CONF_W  configuration sampled on an accepted start
- `fil_valid_i`/`map_valid_i`/`psum_valid_i`  in  1  request valid per class
- `fil_id_i`/`map_id_i`/`psum_id_i`  in  ID_W  target PE id per class
- `fil_data_i`/`map_data_i`/`psum_data_i`  in  DATA_W  payload per class
- `fil_ready_o`/`map_ready_o`/`psum_ready_o`  out  1  grant; a transfer occurs when valid&ready
- `stall_i`  in  1  array backpressure; blocks all grants
- `pe_ready_i`  in  1  AND of all PE `ready` outputs
- `bus_data_o`  out  DATA_W  registered bus payload
- `bus_id_o`  out  ID_W  registered bus id
- `getdata_fil_o`/`getdata_map_o`/`getdata_psum_o`  out  1  registered one-hot strobes
- `conf_o`  out  CONF_W  configuration driven to the PEs
- `busy_o`  out  1  high when not IDLE
- `done_o`  out  1  one-cycle completion pulse
- `xfer_cnt_o`  out  16  transfers in the current pass

## Operation
- FSM states are IDLE, CONFIG, RUN, DRAIN, DONE.
- IDLE→CONFIG on `start_i`. This latches `conf_word_i` into `conf_o` and clears `xfer_cnt_o` and the end flag.
- CONFIG holds for exactly CONF_CYCLES cycles, then moves to RUN. Grants are 0 throughout CONFIG.
- RUN: grants are issued only in RUN and only when `!stall_i`. At most one class is granted per cycle.
  - Round-robin order is fil→map→psum. After a transfer from class k, the next priority starts at k+1. The pointer resets to fil.
  - `*_ready_o` is combinational from the valids, the pointer, the state and `stall_i`. It may be high only when that class's valid is high.
- RUN→DRAIN when the end flag is set and no valid is asserted.
- DRAIN→DONE when `pe_ready_i`=1 and no strobe is pending. DONE lasts 1 cycle (`done_o`=1), then goes to IDLE.
- `end_i` is latched into the end flag in CONFIG or RUN. It is ignored in IDLE, DRAIN and DONE.
- `start_i` is ignored unless the state is IDLE.
- `conf_o` holds its value until the next accepted start.
- `xfer_cnt_o` increments once per transfer. It wraps at 16'hFFFF→0.

## Timing
- Reset values: state IDLE; pointer at fil; all strobes, `busy_o`, `done_o` and all `*_ready_o` are 0; `bus_data_o`, `bus_id_o`, `conf_o` and `xfer_cnt_o` are 0.
- A transfer in cycle t produces registered outputs in cycle t+1: the matching `getdata_*_o`=1 with that class's data and id. Strobe latency is 1.
- Each strobe is high for exactly one cycle per transfer. With no transfer, all strobes are 0 and bus data/id hold their previous values.
- Back-to-back transfers give strobes on consecutive cycles.
- `stall_i` is sampled in the same cycle. With stall and valid both high, there is no grant and the pointer is unchanged.
- `end_i` and a transfer in the same cycle: the transfer completes and the flag is set.
- Reset asserted mid-pass: everything returns to reset values immediately (asynchronous). Pending requests are not acknowledged.
- `busy_o` rises in the cycle after the start is accepted and falls in the cycle after DONE.

## Structure
- Shared package `eyeriss_pkg` holds:
  - the FSM state enum
  - the class encoding (FIL=0, MAP=1, PSUM=2)
  - the DATA_W/ID_W/CONF_W constants
  - the conf field bit positions (enable=25, psum_src=24, id=[7:0])
- One sub-module, `eyeriss_rr_arbiter3`: 3-way round-robin arbiter with req[2:0] and en inputs, grant[2:0] output, and a pointer that advances on grant.

## Test plan
- Reset, then start with conf 26'h2000105 and CONF_CYCLES=2 → `conf_o`=26'h2000105 one cycle after start; no grants for 2 cycles; RUN is entered.
- All three valids held (ids 1/2/3, data A/B/C) → strobes fil, map, psum, fil… on consecutive cycles with matching ids and data; `xfer_cnt_o` counts 1, 2, 3, 4.
- Only map valid, `stall_i` high for 3 cycles → no grant and no strobe for those 3 cycles; grant on the first unstalled cycle; strobe one cycle later.
- `end_i` in the same cycle as the last psum transfer, with `pe_ready_i` low for 4 more cycles → DRAIN for those 4 cycles; `done_o` pulses once after `pe_ready_i` rises; `busy_o` then falls.
- `start_i` during RUN → ignored; `conf_o` is unchanged.
- Assert `Rst` in RUN while a strobe is pending → strobe, ready and busy go to 0 immediately; state is IDLE; `xfer_cnt_o`=0.
